serial_addsub_unit: RTL
=======================

// Module: serial_addsub_unit
// PURPOSE
//  Bit-serial add/subtract unit built around one 1-bit full-adder cell.
//  - Processes one bit per clock, LSB first.
//  - Subtraction is a + ~b + 1: b is inverted and the carry is seeded to 1.
//  - Sits between the register file and the ALU result mux.
//  - Gives area-cheap WIDTH-bit add/sub with a ready/valid handshake on each side.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=2)
//  CNT_W   6    bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      operand request
//  in_ready   out  1      unit can accept operands
//  op_sub     in   1      1 = a - b, 0 = a + b (sampled on accept)
//  a          in   WIDTH  operand A (sampled on accept)
//  b          in   WIDTH  operand B (sampled on accept)
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  sum/difference, modulo 2**WIDTH
//  carry      out  1      add: carry-out; sub: NOT borrow (1 = no borrow)
//  overflow   out  1      two's-complement signed overflow
//  zero       out  1      result == 0
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge):
//   - state=IDLE.
//   - in_ready=1; out_valid=0; result, carry, overflow, zero = 0.
//   - Shift registers and bit counter cleared.
//   - Reset is honoured from any state; an in-flight operation is discarded, no output.
//  IDLE:
//   - in_ready=1.
//   - Accept when in_valid && in_ready at an edge:
//     - A_sr<=a; B_sr<=op_sub ? ~b : b; c<=op_sub; cnt<=0.
//     - Latch sign bits a[W-1] and b_eff[W-1]; state->RUN.
//  RUN:
//   - in_ready=0; in_valid ignored.
//   - Each edge:
//     - s = A_sr[0]^B_sr[0]^c.
//     - c <= (A_sr[0]&B_sr[0]) | (c&(A_sr[0]^B_sr[0])).
//     - R_sr <= {s, R_sr[W-1:1]}.
//     - A_sr and B_sr shift right by 1; cnt <= cnt+1.
//   - After the edge where cnt==WIDTH-1 (WIDTH-th bit): state->DONE, out_valid=1.
//  DONE:
//   - result=R_sr; carry=final c; zero=(R_sr==0).
//   - overflow=(a_sign==b_eff_sign) && (R_sr[W-1]!=a_sign).
//   - Outputs held stable while out_valid && !out_ready.
//   - On out_valid && out_ready: state->IDLE, out_valid<=0.
//   - result and flags keep their last value until the next DONE.
//   - in_ready stays 0 in DONE; a new accept is possible one cycle after the result handshake.
//  Latency:
//   - Accept at edge k -> out_valid=1 after edge k+WIDTH.
//   - Back-to-back throughput: one op per WIDTH+2 cycles.
//  Widths:
//   - Result wraps modulo 2**WIDTH.
//   - No sign extension; flags describe the WIDTH-bit operation only.
// TESTING (WIDTH=8)
//  1 a=0x05,b=0x03,sub -> after 8 cycles: result=0x02,carry=1,ovf=0,zero=0
//  2 a=0x03,b=0x05,sub -> result=0xFE,carry=0 (borrow),ovf=0
//  3 a=0x80,b=0x01,sub -> result=0x7F,ovf=1; a=0x7F,b=0x01,add -> 0x80,ovf=1
//  4 a=0xFF,b=0x01,add -> result=0x00,carry=1,zero=1
//  5 out_ready=0 for 5 cycles after out_valid -> outputs stable; in_ready=0;
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle
//  6 rst_n=0 at RUN cycle 4 -> next cycle IDLE, in_ready=1, out_valid=0,
//    outputs 0; a new op then completes correctly

Source files
------------

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit
//   Bit-serial WIDTH-bit adder/subtractor built around a single full-adder
//   cell. Operands are captured on an input handshake, processed one bit
//   per clock LSB first, and the result is presented on an output handshake.
//   Subtraction is computed as a + ~b + 1 (b inverted, carry seeded to 1).
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid && ready are both 1. A producer holds valid (and its data)
// stable until that edge; ready may rise or fall freely. in_ready is 1 only
// in IDLE; out_valid is 1 only in DONE and stays 1 until the transfer.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      synchronous reset, active-low
//   in_valid   operand request
//   in_ready   unit can accept operands (IDLE)
//   op_sub     1 = a - b, 0 = a + b (sampled on accept)
//   a, b       operands (sampled on accept)
//   out_valid  result valid, held until accepted
//   out_ready  consumer accepts result
//   result     sum/difference modulo 2**WIDTH
//   carry      add: carry-out; sub: NOT borrow (1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       result == 0
module serial_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             a_sign;
  logic             b_sign;

  logic             accept;
  logic             handshake;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] r_next;

  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign last_bit   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // The single full-adder cell and the result shift-in value.
  assign sum_bit    = a_sr[0] ^ b_sr[0] ^ c;
  assign carry_next = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign r_next     = {sum_bit, r_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The result registers are loaded only on the final bit so
  // they hold the previous result throughout the next RUN phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= op_sub ? ~b : b;
      c      <= op_sub;
      cnt    <= '0;
      a_sign <= a[WIDTH-1];
      b_sign <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr <= r_next;
      c    <= carry_next;
      cnt  <= cnt + 1'b1;
      if (last_bit) begin
        result   <= r_next;
        carry    <= carry_next;
        zero     <= (r_next == '0);
        // sum_bit is the result MSB on the final bit.
        overflow <= (a_sign == b_sign) && (sum_bit != a_sign);
      end
    end
  end

endmodule
